// File: rtl/ddr2_sys_onchip_mem_dp_if.sv
// One Avalon-MM slave port of the dual-port on-chip RAM; the RAM takes two of these.
interface ddr2_sys_onchip_mem_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) ();
  localparam int BE_W = DATA_W / 8;

  logic              chipselect;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output chipselect, read, write, address, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  chipselect, read, write, address, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/ddr2_sys_onchip_mem_dp.sv
// Dual-slave Avalon-MM on-chip RAM: two independent ports on one array, RD_LAT-deep read pipeline.
// Define ONCHIP_MEM_CLEAR_EN to zero the whole array after every reset before accepting traffic.
module ddr2_sys_onchip_mem_dp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 38400,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clken,
  input  logic                    reset_req,
  ddr2_sys_onchip_mem_dp_if.slave s1,
  ddr2_sys_onchip_mem_dp_if.slave s2
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("ddr2_sys_onchip_mem_dp: RD_LAT must be 1 or 2");
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("ddr2_sys_onchip_mem_dp: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("ddr2_sys_onchip_mem_dp: DEPTH must be in 1..2**ADDR_W");
  end

  logic [1:0]        cs, rd, wr, acc, wr_acc, rd_acc, in_range;
  logic [ADDR_W-1:0] addr    [2];
  logic [IDX_W-1:0]  idx     [2];
  logic [BE_W-1:0]   be      [2];
  logic [DATA_W-1:0] wdata   [2];
  logic [DATA_W-1:0] rd_word [2];
  logic              en;
  logic              waitreq;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] pv_q    [2];
  logic [RD_LAT-1:0] pv_d    [2];
  logic [DATA_W-1:0] pd_q    [2][RD_LAT];
  logic [DATA_W-1:0] pd_d    [2][RD_LAT];
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  assign cs       = {s2.chipselect, s1.chipselect};
  assign rd       = {s2.read, s1.read};
  assign wr       = {s2.write, s1.write};
  assign addr[0]  = s1.address;
  assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable;
  assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;
  assign wdata[1] = s2.writedata;

  assign en     = clken & ~reset_req;
  assign acc    = cs & (rd | wr) & {2{~waitreq & en}};
  assign wr_acc = acc & wr;
  assign rd_acc = acc & rd & ~wr;

  // Addresses at or above DEPTH never touch the array; the index is only a low-bit slice.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = {1'b0, addr[p]} < (ADDR_W + 1)'(DEPTH);
      idx[p]      = addr[p][IDX_W-1:0];
      rd_word[p]  = in_range[p] ? mem[idx[p]] : '0;
    end
  end

`ifdef ONCHIP_MEM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_addr_q, clr_addr_d;
  logic             clr_we;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    waitreq    = 1'b0;
    case (state_q)
      CLEAR: begin
        waitreq = 1'b1;
        if (en) begin
          clr_we = 1'b1;
          if (clr_addr_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
          else                                 clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end
`else
  assign waitreq = 1'b0;
`endif

  // NOTE: the array is deliberately left out of reset; only the read pipeline is reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
`ifdef ONCHIP_MEM_CLEAR_EN
      if (clr_we) mem[clr_addr_q] <= '0;
`endif
      // s2 is applied first so that s1's later assignment wins lanes enabled on both ports.
      for (int p = 1; p >= 0; p--) begin
        if (wr_acc[p] && in_range[p]) begin
          for (int b = 0; b < BE_W; b++) begin
            if (be[p][b]) mem[idx[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

  // Pipeline stages advance only on enabled edges; the output strobe lasts a single cycle.
  always_comb begin
    pv_d     = pv_q;
    pd_d     = pd_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (en) begin
      for (int p = 0; p < 2; p++) begin
        rvalid_d[p] = pv_q[p][RD_LAT-1];
        if (pv_q[p][RD_LAT-1]) rdata_d[p] = pd_q[p][RD_LAT-1];
        for (int s = RD_LAT - 1; s > 0; s--) begin
          pv_d[p][s] = pv_q[p][s-1];
          pd_d[p][s] = pd_q[p][s-1];
        end
        pv_d[p][0] = rd_acc[p];
        pd_d[p][0] = rd_word[p];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rvalid_q <= '0;
      for (int p = 0; p < 2; p++) begin
        pv_q[p]    <= '0;
        rdata_q[p] <= '0;
        for (int s = 0; s < RD_LAT; s++) pd_q[p][s] <= '0;
      end
    end else begin
      rvalid_q <= rvalid_d;
      pv_q     <= pv_d;
      pd_q     <= pd_d;
      rdata_q  <= rdata_d;
    end
  end

  assign s1.readdata      = rdata_q[0];
  assign s1.readdatavalid = rvalid_q[0];
  assign s1.waitrequest   = waitreq;
  assign s2.readdata      = rdata_q[1];
  assign s2.readdatavalid = rvalid_q[1];
  assign s2.waitrequest   = waitreq;
endmodule

// File: tb/tb_ddr2_sys_onchip_mem_dp.sv
// Directed bench for ddr2_sys_onchip_mem_dp; read results are scored against per-port queues.
// With ONCHIP_MEM_CLEAR_EN defined it also times the post-reset clear sweep.
module tb_ddr2_sys_onchip_mem_dp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 16;
  localparam int RD_LAT = 2;
`ifdef ONCHIP_MEM_CLEAR_EN
  localparam logic WR_RST = 1'b1;
`else
  localparam logic WR_RST = 1'b0;
`endif

  logic clk       = 1'b0;
  logic reset_n   = 1'b0;
  logic clken     = 1'b1;
  logic reset_req = 1'b0;

  always #5 clk = ~clk;

  ddr2_sys_onchip_mem_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s1_if ();
  ddr2_sys_onchip_mem_dp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) s2_if ();

  ddr2_sys_onchip_mem_dp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clken    (clken),
    .reset_req(reset_req),
    .s1       (s1_if),
    .s2       (s2_if)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q1[$];
  logic [31:0] exp_q2[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expectation of its port.
  always @(negedge clk) begin
    if (s1_if.readdatavalid !== 1'b0) begin
      if (exp_q1.size() == 0) check("s1_unexpected_valid", 32'(s1_if.readdatavalid), 32'd0);
      else                    check("s1_readdata", s1_if.readdata, exp_q1.pop_front());
    end
    if (s2_if.readdatavalid !== 1'b0) begin
      if (exp_q2.size() == 0) check("s2_unexpected_valid", 32'(s2_if.readdatavalid), 32'd0);
      else                    check("s2_readdata", s2_if.readdata, exp_q2.pop_front());
    end
  end

  task automatic clr_req();
    s1_if.chipselect = 1'b0; s1_if.read = 1'b0; s1_if.write = 1'b0;
    s2_if.chipselect = 1'b0; s2_if.read = 1'b0; s2_if.write = 1'b0;
  endtask

  task automatic drive(input int p, input logic w, input logic r, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (p == 1) begin
      s1_if.chipselect = 1'b1; s1_if.write = w; s1_if.read = r;
      s1_if.address = a; s1_if.writedata = d; s1_if.byteenable = be;
    end else begin
      s2_if.chipselect = 1'b1; s2_if.write = w; s2_if.read = r;
      s2_if.address = a; s2_if.writedata = d; s2_if.byteenable = be;
    end
  endtask

  task automatic wr(input int p, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(p, 1'b1, 1'b0, a, d, be);
  endtask

  task automatic rd(input int p, input logic [15:0] a, input logic [31:0] exp);
    drive(p, 1'b0, 1'b1, a, 32'h0, 4'h0);
    if (p == 1) exp_q1.push_back(exp);
    else        exp_q2.push_back(exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
    clr_req();
  endtask

  // Called just after the accepting edge: the strobe must show after exactly RD_LAT enabled edges.
  task automatic check_lat(input string tag);
    repeat (RD_LAT - 1) begin
      @(posedge clk); #1;
      check({tag, "_early"}, 32'(s1_if.readdatavalid), 32'd0);
    end
    @(posedge clk); #1;
    check(tag, 32'(s1_if.readdatavalid), 32'd1);
  endtask

`ifdef ONCHIP_MEM_CLEAR_EN
  task automatic count_wait(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s1_if.waitrequest !== 1'b1) break;
      cnt++;
    end
  endtask
`endif

  initial begin
    clr_req();
    s1_if.address = '0; s1_if.writedata = '0; s1_if.byteenable = '0;
    s2_if.address = '0; s2_if.writedata = '0; s2_if.byteenable = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_s1_readdata", s1_if.readdata, 32'h0);
    check("rst_s2_readdata", s2_if.readdata, 32'h0);
    check("rst_s1_valid", 32'(s1_if.readdatavalid), 32'd0);
    check("rst_s2_valid", 32'(s2_if.readdatavalid), 32'd0);
    check("rst_s1_waitrequest", 32'(s1_if.waitrequest), 32'(WR_RST));
    check("rst_s2_waitrequest", 32'(s2_if.waitrequest), 32'(WR_RST));
    reset_n = 1'b1;

`ifdef ONCHIP_MEM_CLEAR_EN
    begin
      int cnt;
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      count_wait(cnt);
      check("clear_wait_cycles_after_restart", 32'(cnt), 32'(DEPTH));
      @(posedge clk); #1;
      for (int i = 0; i < DEPTH; i++) begin
        rd(1, 16'(i), 32'h0);
        step();
      end
      repeat (RD_LAT + 2) step();
    end
`endif

    // Plain write then read, with latency check.
    wr(1, 16'd5, 32'hDEADBEEF, 4'hF); step();
    rd(1, 16'd5, 32'hDEADBEEF);       step();
    check_lat("t1_latency");

    // Partial byte-enable update.
    wr(1, 16'd9, 32'h11223344, 4'hF); step();
    wr(1, 16'd9, 32'hAAAAAAAA, 4'h2); step();
    rd(1, 16'd9, 32'h1122AA44);       step();

    // Same-cycle writes from both ports.
    wr(1, 16'd7, 32'h11111111, 4'h3); wr(2, 16'd7, 32'h22222222, 4'hC); step();
    rd(2, 16'd7, 32'h22221111); step();
    wr(1, 16'd7, 32'h11111111, 4'hF); wr(2, 16'd7, 32'h22222222, 4'hF); step();
    rd(1, 16'd7, 32'h11111111); step();
    wr(1, 16'd8, 32'hAAAAAAAA, 4'h6); wr(2, 16'd8, 32'hBBBBBBBB, 4'hF); step();
    rd(2, 16'd8, 32'hBBAAAABB); step();

    // Read-during-write returns old data; write+read on one port is a write only.
    wr(1, 16'd3, 32'd9, 4'hF); step();
    wr(1, 16'd3, 32'd5, 4'hF); rd(2, 16'd3, 32'd9); step();
    rd(2, 16'd3, 32'd5); step();
    drive(1, 1'b1, 1'b1, 16'd3, 32'd7, 4'hF); step();
    rd(1, 16'd3, 32'd7); step();
    wr(2, 16'd3, 32'h0C, 4'hF); rd(1, 16'd3, 32'd7); step();
    rd(1, 16'd3, 32'h0C); step();

    // Back-to-back reads on both ports.
    rd(1, 16'd5, 32'hDEADBEEF); rd(2, 16'd9, 32'h1122AA44); step();
    rd(1, 16'd9, 32'h1122AA44); rd(2, 16'd5, 32'hDEADBEEF); step();
    rd(1, 16'd7, 32'h11111111); rd(2, 16'd8, 32'hBBAAAABB); step();
    repeat (RD_LAT + 2) step();

    // Stall via clken low, then via reset_req high.
    for (int m = 0; m < 2; m++) begin
      rd(1, 16'd9, 32'h1122AA44); step();
      if (m == 0) clken = 1'b0;
      else        reset_req = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        check("stall_no_valid", 32'(s1_if.readdatavalid), 32'd0);
      end
      clken = 1'b1; reset_req = 1'b0;
      check_lat("stall_latency");
      step();
      check("readdata_held", s1_if.readdata, 32'h1122AA44);
    end

    // Reset with a read in flight: no strobe, outputs cleared, array kept.
    drive(1, 1'b0, 1'b1, 16'd5, 32'h0, 4'h0); step();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("midreset_readdata", s1_if.readdata, 32'h0);
    check("midreset_valid", 32'(s1_if.readdatavalid), 32'd0);
`ifdef ONCHIP_MEM_CLEAR_EN
    begin
      int cnt;
      count_wait(cnt);
      check("clear_wait_cycles", 32'(cnt), 32'(DEPTH));
      @(posedge clk); #1;
      wr(1, 16'd5, 32'hDEADBEEF, 4'hF); step();
    end
`else
    repeat (RD_LAT + 3) step();
`endif
    rd(1, 16'd5, 32'hDEADBEEF); step();

    // Out-of-range accesses.
    rd(1, 16'(DEPTH), 32'h0); step();
    wr(1, 16'(DEPTH + 5), 32'h12345678, 4'hF); step();
    rd(1, 16'd5, 32'hDEADBEEF); step();
    repeat (RD_LAT + 4) step();

    check("s1_queue_drained", 32'(exp_q1.size()), 32'd0);
    check("s2_queue_drained", 32'(exp_q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
